// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and SR/Cause field positions.
package cp0_defs;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_BD_BIT  = 31;

    // Word-aligned return address; a delay-slot fault restarts at the branch.
    function automatic logic [29:0] epc_from_pc(input logic [31:0] pc, input logic bd);
        logic [31:0] adj;
        adj = bd ? (pc - 32'd4) : pc;
        return adj[31:2];
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_arbiter.sv
// Combinational request arbiter: interrupt vs. synchronous exception, both blocked while EXL is set.
module cp0_int_arbiter
    import cp0_defs::*;
(
    input  logic [5:0] hwint_i,
    input  logic [5:0] im_i,
    input  logic       ie_i,
    input  logic       exl_i,
    input  logic [4:0] exc_code_i,
    output logic       int_req_o,
    output logic       exc_req_o,
    output logic       req_o,
    output logic [4:0] sel_code_o
);

    assign int_req_o  = (|(hwint_i & im_i)) & ie_i & ~exl_i;
    assign exc_req_o  = (exc_code_i != 5'd0) & ~exl_i;
    assign req_o      = int_req_o | exc_req_o;
    // Interrupt outranks a synchronous exception raised in the same cycle.
    assign sel_code_o = int_req_o ? EXC_INT : exc_code_i;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M-stage boundary: SR/Cause/EPC/PRId and the flush request.
module cp0_exc_ctrl
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL  = 32'h2022_1202
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] M_PC,
    input  logic        M_BD,
    input  logic [4:0]  M_EXC_Code,
    input  logic        EXLClr,
    input  logic [5:0]  HWInt,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut,
    output logic [31:0] ExcPC,
    output logic        Req
);

    logic [5:0]  sr_im_q,     sr_im_d;
    logic        sr_exl_q,    sr_exl_d;
    logic        sr_ie_q,     sr_ie_d;
    logic        cause_bd_q,  cause_bd_d;
    logic [5:0]  cause_ip_q,  cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [29:0] epc_q,       epc_d;

    logic        int_req;
    logic        exc_req;
    logic        arb_req;
    logic [4:0]  sel_code;
    logic        unused_req_split;

    cp0_int_arbiter u_arbiter (
        .hwint_i    (HWInt),
        .im_i       (sr_im_q),
        .ie_i       (sr_ie_q),
        .exl_i      (sr_exl_q),
        .exc_code_i (M_EXC_Code),
        .int_req_o  (int_req),
        .exc_req_o  (exc_req),
        .req_o      (arb_req),
        .sel_code_o (sel_code)
    );

    assign unused_req_split = int_req ^ exc_req;

    // SR is cleared in reset, but a pending exception code alone would still raise a request.
    assign Req   = arb_req & reset;
    assign ExcPC = EXC_ENTRY;

    // An mtc0 EPC in M is forwarded so a directly following eret returns to the new address.
    assign EPCOut = (WE && (A2 == REG_EPC)) ? {DIn[31:2], 2'b00} : {epc_q, 2'b00};

    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR: begin
                DOut[SR_IM_LSB +: 6] = sr_im_q;
                DOut[SR_EXL_BIT]     = sr_exl_q;
                DOut[SR_IE_BIT]      = sr_ie_q;
            end
            REG_CAUSE: begin
                DOut[CAUSE_BD_BIT]         = cause_bd_q;
                DOut[CAUSE_IP_LSB +: 6]    = cause_ip_q;
                DOut[CAUSE_EXC_LSB +: 5]   = cause_exc_q;
            end
            REG_EPC:  DOut = {epc_q, 2'b00};
            REG_PRID: DOut = PRID_VAL;
            default:  DOut = 32'd0;
        endcase
    end

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = HWInt;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (Req) begin
            // Taking the exception discards any mtc0/eret sitting in M.
            sr_exl_d    = 1'b1;
            cause_bd_d  = M_BD;
            cause_exc_d = sel_code;
            epc_d       = epc_from_pc(M_PC, M_BD);
        end else begin
            if (WE) begin
                case (A2)
                    REG_SR: begin
                        sr_im_d  = DIn[SR_IM_LSB +: 6];
                        sr_exl_d = DIn[SR_EXL_BIT];
                        sr_ie_d  = DIn[SR_IE_BIT];
                    end
                    REG_EPC: epc_d = DIn[31:2];
                    default: ;
                endcase
            end
            if (EXLClr) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 30'd0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with hand-computed register and request values.
`timescale 1ns/1ps
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] M_PC;
    logic        M_BD;
    logic [4:0]  M_EXC_Code;
    logic        EXLClr;
    logic [5:0]  HWInt;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic [31:0] ExcPC;
    logic        Req;

    int n_checks = 0;
    int n_errors = 0;

    cp0_exc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .A1         (A1),
        .A2         (A2),
        .DIn        (DIn),
        .WE         (WE),
        .M_PC       (M_PC),
        .M_BD       (M_BD),
        .M_EXC_Code (M_EXC_Code),
        .EXLClr     (EXLClr),
        .HWInt      (HWInt),
        .DOut       (DOut),
        .EPCOut     (EPCOut),
        .ExcPC      (ExcPC),
        .Req        (Req)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] r, input logic [31:0] exp, input string tag);
        A1 = r;
        #1;
        check(tag, DOut, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0;
        M_PC = 32'd0; M_BD = 1'b0; M_EXC_Code = 5'd10; EXLClr = 1'b0; HWInt = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'd0, Req}, 32'd0);
        rd(5'd12, 32'd0, "rst_sr");
        rd(5'd13, 32'd0, "rst_cause");
        rd(5'd14, 32'd0, "rst_epc");
        rd(5'd15, 32'h2022_1202, "prid");
        rd(5'd3, 32'd0, "unmapped");
        check("excpc", ExcPC, 32'h0000_4180);
        M_EXC_Code = 5'd0;
        reset = 1'b1;

        // Synchronous exception, no delay slot
        tick();
        M_PC = 32'h3010; M_EXC_Code = 5'd12;
        #1 check("exc_req", {31'd0, Req}, 32'd1);
        tick();
        M_EXC_Code = 5'd0;
        #1 check("exc_req_done", {31'd0, Req}, 32'd0);
        rd(5'd12, 32'h0000_0002, "exc_sr");
        rd(5'd13, 32'h0000_0030, "exc_cause");
        rd(5'd14, 32'h0000_3010, "exc_epc");
        M_EXC_Code = 5'd5; HWInt = 6'h3f;
        #1 check("nest_block", {31'd0, Req}, 32'd0);
        M_EXC_Code = 5'd0; HWInt = 6'd0;

        // Asynchronous reset between edges
        #2 reset = 1'b0; M_EXC_Code = 5'd10;
        #1 check("mid_rst_req", {31'd0, Req}, 32'd0);
        rd(5'd12, 32'd0, "mid_rst_sr");
        rd(5'd13, 32'd0, "mid_rst_cause");
        rd(5'd14, 32'd0, "mid_rst_epc");
        M_EXC_Code = 5'd0;
        reset = 1'b1;

        // Exception in a branch delay slot
        tick();
        M_BD = 1'b1; M_PC = 32'h3024; M_EXC_Code = 5'd4;
        #1 check("bd_req", {31'd0, Req}, 32'd1);
        tick();
        M_BD = 1'b0; M_EXC_Code = 5'd0; EXLClr = 1'b1;
        rd(5'd14, 32'h0000_3020, "bd_epc");
        rd(5'd13, 32'h8000_0010, "bd_cause");
        rd(5'd12, 32'h0000_0002, "bd_sr");
        tick();
        EXLClr = 1'b0;
        rd(5'd12, 32'd0, "eret_sr");

        // Interrupt enabled through SR, then a masked line
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick();
        WE = 1'b0;
        rd(5'd12, 32'h0000_0401, "mtc0_sr");
        HWInt = 6'b000001; M_PC = 32'h3100;
        #1 check("int_req", {31'd0, Req}, 32'd1);
        tick();
        HWInt = 6'd0; EXLClr = 1'b1;
        rd(5'd13, 32'h0000_0400, "int_cause");
        rd(5'd12, 32'h0000_0403, "int_sr");
        rd(5'd14, 32'h0000_3100, "int_epc");
        tick();
        EXLClr = 1'b0; HWInt = 6'b000010;
        rd(5'd12, 32'h0000_0401, "int_eret_sr");
        check("masked_req", {31'd0, Req}, 32'd0);
        tick();
        rd(5'd13, 32'h0000_0800, "ip_track");

        // Interrupt and exception together, then re-request right after eret
        HWInt = 6'b000001; M_EXC_Code = 5'd10; M_PC = 32'h3200;
        #1 check("both_req", {31'd0, Req}, 32'd1);
        tick();
        M_EXC_Code = 5'd0; EXLClr = 1'b1;
        rd(5'd13, 32'h0000_0400, "both_cause");
        check("eret_cycle_req", {31'd0, Req}, 32'd0);
        tick();
        EXLClr = 1'b0;
        #1 check("reint_req", {31'd0, Req}, 32'd1);
        rd(5'd12, 32'h0000_0401, "reint_sr");
        tick();
        HWInt = 6'd0; EXLClr = 1'b1;
        rd(5'd12, 32'h0000_0403, "reint_taken_sr");
        tick();
        EXLClr = 1'b0;
        rd(5'd12, 32'h0000_0401, "reint_eret_sr");

        // mtc0 EPC forwarded to an eret in the next cycle
        WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3007;
        #1 check("fwd_epcout", EPCOut, 32'h0000_3004);
        rd(5'd14, 32'h0000_3200, "no_write_through");
        tick();
        WE = 1'b0; EXLClr = 1'b1;
        #1 check("eret_epcout", EPCOut, 32'h0000_3004);
        rd(5'd14, 32'h0000_3004, "epc_committed");
        tick();
        EXLClr = 1'b0;

        // Writes to Cause are ignored
        WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        WE = 1'b0;
        rd(5'd13, 32'h0000_0000, "cause_ro");

        // Request beats a simultaneous mtc0 and eret
        M_PC = 32'h3300; M_EXC_Code = 5'd12;
        WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_5678; EXLClr = 1'b1;
        #1 check("prio_req", {31'd0, Req}, 32'd1);
        tick();
        M_EXC_Code = 5'd0; WE = 1'b0;
        rd(5'd14, 32'h0000_3300, "prio_epc");
        rd(5'd12, 32'h0000_0403, "prio_sr");
        tick();
        EXLClr = 1'b0;
        rd(5'd12, 32'h0000_0401, "prio_eret_sr");

        // Delay-slot PC of zero wraps around
        M_BD = 1'b1; M_PC = 32'h0000_0000; M_EXC_Code = 5'd5;
        #1 check("wrap_req", {31'd0, Req}, 32'd1);
        tick();
        M_BD = 1'b0; M_EXC_Code = 5'd0;
        rd(5'd14, 32'hFFFF_FFFC, "wrap_epc");
        rd(5'd13, 32'h8000_0014, "wrap_cause");
        check("wrap_epcout", EPCOut, 32'hFFFF_FFFC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
